// File: rtl/sms32_inv_power_38_pkg.sv
// Shared state type, exponent constants and basis-change helpers for the SMS32 power engine.
// The polynomial basis is GF(2)[x]/(x^6+x^5+x^3+x^2+1); x maps to the composite generator Y.
package sms32_pkg;

  localparam int unsigned GF_W   = 6;
  localparam int unsigned HALF_W = 3;
  localparam int unsigned STEP_W = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  // Composite element hi*Y + lo with hi, lo in GF(2^3)
  typedef struct packed {
    logic [HALF_W-1:0] hi;
    logic [HALF_W-1:0] lo;
  } comp_t;

  localparam logic [GF_W-1:0]   EXP_INV   = 6'd38;
  localparam logic [GF_W-1:0]   EXP_FWD   = 6'd5;
  localparam logic [STEP_W-1:0] LAST_STEP = 3'd5;

  // GF(2^3) uses z^3+z+1; Y^2 = Y + LAMBDA with LAMBDA = z+1 (trace 1, so irreducible)
  localparam logic [HALF_W-1:0] GF8_LAMBDA = 3'b011;
  localparam logic [GF_W-1:0]   COMP_ONE   = 6'b000_001;

  function automatic logic [HALF_W-1:0] gf8_mul(input logic [HALF_W-1:0] a,
                                                 input logic [HALF_W-1:0] b);
    logic [4:0] p;
    p = '0;
    for (int i = 0; i < 3; i++) begin
      if (b[i]) p = p ^ (5'(a) << i);
    end
    // fold z^3 -> z+1 and z^4 -> z^2+z
    return p[2:0] ^ {1'b0, p[3], p[3]} ^ {p[4], p[4], 1'b0};
  endfunction

  function automatic logic [HALF_W-1:0] gf8_mul_lambda(input logic [HALF_W-1:0] a);
    return gf8_mul(a, GF8_LAMBDA);
  endfunction

  // Columns are Y^0..Y^5 written as {hi,lo}: 01,08,0B,13,0E,3B
  function automatic logic [GF_W-1:0] iso(input logic [GF_W-1:0] x);
    logic [GF_W-1:0] w;
    w[0] = x[0] ^ x[2] ^ x[3] ^ x[5];
    w[1] = x[2] ^ x[3] ^ x[4] ^ x[5];
    w[2] = x[4];
    w[3] = x[1] ^ x[2] ^ x[4] ^ x[5];
    w[4] = x[3] ^ x[5];
    w[5] = x[5];
    return w;
  endfunction

  function automatic logic [GF_W-1:0] inv_iso(input logic [GF_W-1:0] w);
    logic [GF_W-1:0] x;
    x[0] = w[0] ^ w[1] ^ w[2];
    x[1] = w[1] ^ w[3] ^ w[4] ^ w[5];
    x[2] = w[1] ^ w[2] ^ w[4];
    x[3] = w[4] ^ w[5];
    x[4] = w[2];
    x[5] = w[5];
    return x;
  endfunction

endpackage

// File: rtl/sms32_inv_power_38_gf64_comp_mul.sv
// Combinational GF((2^3)^2) multiplier: three GF(2^3) products (Karatsuba) plus LAMBDA scaling.
module gf64_comp_mul
  import sms32_pkg::*;
(
  input  logic [GF_W-1:0] i_a,
  input  logic [GF_W-1:0] i_b,
  output logic [GF_W-1:0] o_p_c
);

  comp_t             w_a;
  comp_t             w_b;
  comp_t             w_p;
  logic [HALF_W-1:0] w_hh;
  logic [HALF_W-1:0] w_ll;
  logic [HALF_W-1:0] w_mid;

  assign w_a = comp_t'(i_a);
  assign w_b = comp_t'(i_b);

  assign w_hh  = gf8_mul(w_a.hi, w_b.hi);
  assign w_ll  = gf8_mul(w_a.lo, w_b.lo);
  assign w_mid = gf8_mul(w_a.hi ^ w_a.lo, w_b.hi ^ w_b.lo);

  // (a1 Y + a0)(b1 Y + b0) with Y^2 = Y + LAMBDA
  assign w_p.hi = w_mid ^ w_ll;
  assign w_p.lo = w_ll ^ gf8_mul_lambda(w_hh);

  assign o_p_c = GF_W'(w_p);

endmodule

// File: rtl/sms32_inv_power_38.sv
// Iterative x^38 (inverse SMS32 S-box) engine, LSB-first square-and-multiply over six steps.
// Define SMS32_FWD_MODE_EN to add the mode port selecting the forward x^5 map.
module sms32_inv_power_38
  import sms32_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [GF_W-1:0] in_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [GF_W-1:0] out_data
`ifdef SMS32_FWD_MODE_EN
  ,
  input  logic            mode
`endif
);

  state_t              r_state;
  logic [GF_W-1:0]     r_acc;
  logic [GF_W-1:0]     r_sq;
  logic [STEP_W-1:0]   r_step;
  logic [GF_W-1:0]     r_exp;
  logic                r_in_ready;
  logic                r_out_valid;
  logic [GF_W-1:0]     r_out_data;

  state_t              w_state_nxt;
  logic [GF_W-1:0]     w_acc_nxt;
  logic [GF_W-1:0]     w_sq_nxt;
  logic [STEP_W-1:0]   w_step_nxt;
  logic [GF_W-1:0]     w_exp_nxt;
  logic [GF_W-1:0]     w_out_data_nxt;
  logic [GF_W-1:0]     w_acc_prod;
  logic [GF_W-1:0]     w_sq_prod;
  logic [GF_W-1:0]     w_exp_sel;

`ifdef SMS32_FWD_MODE_EN
  assign w_exp_sel = mode ? EXP_FWD : EXP_INV;
`else
  assign w_exp_sel = EXP_INV;
`endif

  gf64_comp_mul u_mul_acc (
    .i_a   (r_acc),
    .i_b   (r_sq),
    .o_p_c (w_acc_prod)
  );

  gf64_comp_mul u_mul_sq (
    .i_a   (r_sq),
    .i_b   (r_sq),
    .o_p_c (w_sq_prod)
  );

  // Next-state and datapath update
  always_comb begin
    w_state_nxt    = r_state;
    w_acc_nxt      = r_acc;
    w_sq_nxt       = r_sq;
    w_step_nxt     = r_step;
    w_exp_nxt      = r_exp;
    w_out_data_nxt = r_out_data;
    case (r_state)
      IDLE: begin
        if (in_valid) begin
          w_sq_nxt    = iso(in_data);
          w_acc_nxt   = COMP_ONE;
          w_step_nxt  = '0;
          w_exp_nxt   = w_exp_sel;
          w_state_nxt = CALC;
        end
      end
      CALC: begin
        if (r_exp[r_step]) w_acc_nxt = w_acc_prod;
        w_sq_nxt = w_sq_prod;
        if (r_step == LAST_STEP) begin
          w_out_data_nxt = inv_iso(w_acc_nxt);
          w_state_nxt    = DONE;
        end else begin
          w_step_nxt = r_step + 3'd1;
        end
      end
      DONE: begin
        if (out_ready) w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_acc       <= '0;
      r_sq        <= '0;
      r_step      <= '0;
      r_exp       <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_acc       <= w_acc_nxt;
      r_sq        <= w_sq_nxt;
      r_step      <= w_step_nxt;
      r_exp       <= w_exp_nxt;
      r_in_ready  <= (w_state_nxt == IDLE);
      r_out_valid <= (w_state_nxt == DONE);
      r_out_data  <= w_out_data_nxt;
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;

endmodule

// File: tb/tb_sms32_inv_power_38.sv
// Self-checking bench for sms32_inv_power_38: polynomial-basis GF(2^6) model plus directed vectors.
module tb_sms32_inv_power_38;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [5:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [5:0] out_data;
`ifdef SMS32_FWD_MODE_EN
  logic       mode;
`endif

  int tot = 0;
  int bad = 0;

  always #5 clk = ~clk;

  sms32_inv_power_38 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
`ifdef SMS32_FWD_MODE_EN
    ,
    .mode      (mode)
`endif
  );

  // GF(2^6) multiply in the polynomial basis, modulus x^6+x^5+x^3+x^2+1
  function automatic logic [5:0] pmul(input logic [5:0] a, input logic [5:0] b);
    logic [10:0] p;
    p = '0;
    for (int i = 0; i < 6; i++) if (b[i]) p = p ^ (11'(a) << i);
    for (int k = 10; k >= 6; k--) if (p[k]) p = p ^ (11'h06D << (k - 6));
    return p[5:0];
  endfunction

  function automatic logic [5:0] gf_pow(input logic [5:0] x, input int e);
    logic [5:0] r;
    r = 6'd1;
    for (int i = 0; i < e; i++) r = pmul(r, x);
    return r;
  endfunction

  function automatic int cur_exp();
`ifdef SMS32_FWD_MODE_EN
    return mode ? 5 : 38;
`else
    return 38;
`endif
  endfunction

  task automatic check(input string nm, input logic [7:0] got, input logic [7:0] want);
    tot++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s t=%0t got=%h want=%h", nm, $time, got, want);
    end
  endtask

  // Transaction-level model: accept in IDLE, result visible 6 edges later, held until out_ready
  int         m_phase = 0;
  int         m_cnt   = 0;
  logic [5:0] m_res   = '0;
  logic       m_ov    = 1'b0;
  logic [5:0] m_od    = '0;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_phase = 0;
      m_cnt   = 0;
      m_ov    = 1'b0;
      m_od    = '0;
    end else begin
      case (m_phase)
        0: if (in_valid) begin
          m_phase = 1;
          m_cnt   = 0;
          m_res   = gf_pow(in_data, cur_exp());
        end
        1: begin
          m_cnt++;
          if (m_cnt == 6) begin
            m_phase = 2;
            m_ov    = 1'b1;
            m_od    = m_res;
          end
        end
        default: if (out_ready) begin
          m_phase = 0;
          m_ov    = 1'b0;
        end
      endcase
    end
  end

  always @(posedge clk) begin
    #2;
    check("cyc_in_ready", 8'(in_ready), 8'(m_phase == 0));
    check("cyc_out_valid", 8'(out_valid), 8'(m_ov));
    check("cyc_out_data", 8'(out_data), 8'(m_od));
  end

  task automatic wait_idle();
    int guard;
    guard = 0;
    @(negedge clk);
    while (in_ready !== 1'b1 && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 40) check("idle_timeout", 8'(guard), 8'd0);
  endtask

  task automatic wait_result(output int lat);
    lat = 0;
    while (out_valid !== 1'b1 && lat < 30) begin
      @(posedge clk);
      #1;
      lat++;
    end
    if (lat >= 30) check("result_timeout", 8'(lat), 8'd6);
  endtask

  task automatic run_one(input logic [5:0] x, output logic [5:0] y, output int lat);
    wait_idle();
    in_valid = 1'b1;
    in_data  = x;
    @(posedge clk);
    #1;
    check("in_ready_T1", 8'(in_ready), 8'd0);
    @(negedge clk);
    in_valid = 1'b0;
    wait_result(lat);
    lat = lat + 1;
    y = out_data;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0]  y;
    logic [5:0]  d;
    logic [63:0] seen;
    int          lat;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
`ifdef SMS32_FWD_MODE_EN
    mode      = 1'b0;
`endif
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rst_in_ready", 8'(in_ready), 8'd1);
    check("rst_out_valid", 8'(out_valid), 8'd0);
    check("rst_out_data", 8'(out_data), 8'd0);

    // Hand-derived powers of alpha pin the model
    check("pin_a6", 8'(gf_pow(6'h02, 6)), 8'h2D);
    check("pin_a38", 8'(gf_pow(6'h02, 38)), 8'h21);
    check("pin_a36", 8'(gf_pow(6'h02, 36)), 8'h13);

    // Zero input; latency counted in edges including the acceptance edge
    run_one(6'd0, y, lat);
    check("zero_lat", 8'(lat), 8'd7);
    check("zero_val", 8'(y), 8'd0);
    run_one(6'd1, y, lat);
    check("one_val", 8'(y), 8'd1);
    run_one(6'd2, y, lat);
    check("alpha_val", 8'(y), 8'h21);
    check("alpha_lat", 8'(lat), 8'd7);

    // Exhaustive: every result raised to 5 returns the input, all outputs distinct
    seen = '0;
    for (int x = 0; x < 64; x++) begin
      run_one(6'(x), y, lat);
      check("exh_pow5", 8'(gf_pow(y, 5)), 8'(x));
      seen[y] = 1'b1;
    end
    check("exh_distinct", 8'($countones(seen)), 8'd64);

    // Backpressure: hold result for 10 cycles
    wait_idle();
    out_ready = 1'b0;
    run_one(6'h2D, y, lat);
    d = y;
    check("bp_val", 8'(d), 8'(gf_pow(6'h2D, 38)));
    for (int k = 0; k < 10; k++) begin
      @(posedge clk);
      #1;
      check("bp_valid", 8'(out_valid), 8'd1);
      check("bp_data", 8'(out_data), 8'(d));
      check("bp_in_ready", 8'(in_ready), 8'd0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp_release_ready", 8'(in_ready), 8'd1);
    check("bp_release_valid", 8'(out_valid), 8'd0);

    // New in_valid/in_data during CALC is ignored
    wait_idle();
    in_valid = 1'b1;
    in_data  = 6'h13;
    @(posedge clk);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      in_valid = (k % 2 == 0);
      in_data  = 6'(6'h20 + k);
    end
    @(negedge clk);
    in_valid = 1'b0;
    wait_result(lat);
    check("ignore_val", 8'(out_data), 8'(gf_pow(6'h13, 38)));

    // Reset mid-operation discards the partial result
    wait_idle();
    in_valid = 1'b1;
    in_data  = 6'h15;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk);
      #1;
      check("rstmid_valid", 8'(out_valid), 8'd0);
    end
    check("rstmid_ready", 8'(in_ready), 8'd1);
    run_one(6'h2A, y, lat);
    check("rstmid_lat", 8'(lat), 8'd7);
    check("rstmid_val", 8'(y), 8'(gf_pow(6'h2A, 38)));

    // Reset wins over simultaneous in_valid
    wait_idle();
    rst_n    = 1'b0;
    in_valid = 1'b1;
    in_data  = 6'h05;
    @(negedge clk);
    rst_n    = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk);
      #1;
      check("rstvalid_valid", 8'(out_valid), 8'd0);
      check("rstvalid_ready", 8'(in_ready), 8'd1);
    end

`ifdef SMS32_FWD_MODE_EN
    // Forward then inverse round trip for every value
    for (int x = 0; x < 64; x++) begin
      logic [5:0] p;
      mode = 1'b1;
      run_one(6'(x), p, lat);
      check("fwd_val", 8'(p), 8'(gf_pow(6'(x), 5)));
      check("fwd_lat", 8'(lat), 8'd7);
      mode = 1'b0;
      run_one(p, y, lat);
      check("roundtrip", 8'(y), 8'(x));
    end
`endif

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", tot, bad);
    $finish;
  end

endmodule
